// File: rtl/magnetron_timer.sv
// Microwave cook-time countdown: BCD mm:ss keypad entry, 1 Hz countdown while mag_on.
// Optional completion beep is built only when MAG_TIMER_BEEP_EN is defined.
module magnetron_timer #(
  parameter int unsigned TICK_DIV    = 50_000_000,
  parameter int unsigned BEEP_CYCLES = 25_000_000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        mag_on,
  input  logic        clearn,
  input  logic        key_valid,
  input  logic [3:0]  key_digit,
  output logic [15:0] time_bcd,
  output logic        timer_done,
  output logic        beep
);

  localparam int unsigned PRE_W = $clog2(TICK_DIV);
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_DIV - 1);

  logic [15:0]      time_q, time_d, dec_time;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic             run, tick, clr_acc, key_acc, tick_zero;

  assign timer_done = (time_q == '0);
  assign run        = mag_on && !timer_done;
  assign tick       = run && (pre_q == PRE_MAX);
  assign clr_acc    = !mag_on && !clearn;
  assign key_acc    = !mag_on && clearn && key_valid && (key_digit <= 4'd9);
  assign tick_zero  = tick && (dec_time == '0);
  assign time_bcd   = time_q;

  // BCD borrow chain: sec ones -> sec tens (reload 5) -> min ones -> min tens
  always_comb begin
    dec_time = time_q;
    if (time_q[3:0] != 4'd0) begin
      dec_time[3:0] = time_q[3:0] - 4'd1;
    end else begin
      dec_time[3:0] = 4'd9;
      if (time_q[7:4] != 4'd0) begin
        dec_time[7:4] = time_q[7:4] - 4'd1;
      end else begin
        dec_time[7:4] = 4'd5;
        if (time_q[11:8] != 4'd0) begin
          dec_time[11:8] = time_q[11:8] - 4'd1;
        end else begin
          dec_time[11:8]  = 4'd9;
          dec_time[15:12] = time_q[15:12] - 4'd1;
        end
      end
    end
  end

  always_comb begin
    time_d = time_q;
    pre_d  = '0;
    if (clr_acc) begin
      time_d = '0;
    end else if (key_acc) begin
      time_d = {time_q[11:0], key_digit};
    end else if (tick) begin
      time_d = dec_time;
    end
    if (run && !tick) begin
      pre_d = pre_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      time_q <= '0;
      pre_q  <= '0;
    end else begin
      time_q <= time_d;
      pre_q  <= pre_d;
    end
  end

`ifdef MAG_TIMER_BEEP_EN
  localparam int unsigned BEEP_W = $clog2(BEEP_CYCLES + 1);

  logic [BEEP_W-1:0] beep_cnt_q, beep_cnt_d;

  always_comb begin
    beep_cnt_d = beep_cnt_q;
    if (clr_acc || key_acc) begin
      beep_cnt_d = '0;
    end else if (tick_zero) begin
      beep_cnt_d = BEEP_W'(BEEP_CYCLES);
    end else if (beep_cnt_q != '0) begin
      beep_cnt_d = beep_cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) beep_cnt_q <= '0;
    else       beep_cnt_q <= beep_cnt_d;
  end

  assign beep = (beep_cnt_q != '0);
`else
  // Constant 0; the terms keep the parameter and completion decode referenced.
  assign beep = 1'b0 & (BEEP_CYCLES == 0) & tick_zero;
`endif

endmodule

// File: tb/tb_magnetron_timer.sv
// Scoreboard bench for magnetron_timer (TICK_DIV=4, BEEP_CYCLES=6).
// Beep expectations follow MAG_TIMER_BEEP_EN as defined for the build.
module tb_magnetron_timer;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        mag_on = 1'b0;
  logic        clearn = 1'b1;
  logic        key_valid = 1'b0;
  logic [3:0]  key_digit = 4'd0;
  logic [15:0] time_bcd;
  logic        timer_done;
  logic        beep;

`ifdef MAG_TIMER_BEEP_EN
  localparam logic BEEP_ON = 1'b1;
`else
  localparam logic BEEP_ON = 1'b0;
`endif

  localparam int SEL_TIME = 0;
  localparam int SEL_DONE = 1;
  localparam int SEL_BEEP = 2;

  typedef struct {
    string       tag;
    int          sel;
    logic [15:0] exp;
  } sb_entry_t;

  sb_entry_t sb_q[$];
  int        n_tests = 0;
  int        n_fail  = 0;

  magnetron_timer #(.TICK_DIV(4), .BEEP_CYCLES(6)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .mag_on     (mag_on),
    .clearn     (clearn),
    .key_valid  (key_valid),
    .key_digit  (key_digit),
    .time_bcd   (time_bcd),
    .timer_done (timer_done),
    .beep       (beep)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic sb_push(input string tag, input int sel, input logic [15:0] exp);
    sb_entry_t e;
    e.tag = tag;
    e.sel = sel;
    e.exp = exp;
    sb_q.push_back(e);
  endtask

  task automatic sb_drain();
    sb_entry_t   e;
    logic [15:0] obs;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      case (e.sel)
        SEL_TIME: obs = time_bcd;
        SEL_DONE: obs = {15'd0, timer_done};
        default:  obs = {15'd0, beep};
      endcase
      check_eq(e.tag, obs, e.exp);
    end
  endtask

  task automatic expect_state(input string tag, input logic [15:0] t, input logic bp);
    sb_push({tag, "_time"}, SEL_TIME, t);
    sb_push({tag, "_done"}, SEL_DONE, {15'd0, (t == 16'h0000)});
    sb_push({tag, "_beep"}, SEL_BEEP, {15'd0, bp});
    sb_drain();
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic key(input logic [3:0] d);
    key_valid = 1'b1;
    key_digit = d;
    step(1);
    key_valid = 1'b0;
  endtask

  task automatic load(input logic [15:0] v);
    mag_on = 1'b0;
    clearn = 1'b0;
    step(1);
    clearn = 1'b1;
    key(v[15:12]);
    key(v[11:8]);
    key(v[7:4]);
    key(v[3:0]);
  endtask

  initial begin
    // 1: reset and entry
    #12;
    expect_state("rst", 16'h0000, 1'b0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    key(4'd1);
    key(4'd3);
    key(4'd0);
    expect_state("entry", 16'h0130, 1'b0);

    // 2: countdown to zero
    load(16'h0002);
    mag_on = 1'b1;
    step(3);
    expect_state("cd_wait", 16'h0002, 1'b0);
    step(1);
    expect_state("cd_1", 16'h0001, 1'b0);
    step(4);
    expect_state("cd_0", 16'h0000, BEEP_ON);
    step(5);
    expect_state("cd_hold", 16'h0000, BEEP_ON);
    mag_on = 1'b0;

    // 3: borrow chain
    load(16'h0100);
    mag_on = 1'b1;
    step(4);
    expect_state("borrow_0100", 16'h0059, 1'b0);
    load(16'h1000);
    mag_on = 1'b1;
    step(4);
    expect_state("borrow_1000", 16'h0959, 1'b0);
    load(16'h0190);
    mag_on = 1'b1;
    step(4);
    expect_state("borrow_0190", 16'h0189, 1'b0);

    // 4: pause / resume / guard
    load(16'h0130);
    mag_on = 1'b1;
    step(6);
    expect_state("pause_run", 16'h0129, 1'b0);
    mag_on = 1'b0;
    step(3);
    expect_state("pause_frz", 16'h0129, 1'b0);
    mag_on = 1'b1;
    step(3);
    expect_state("resume_3", 16'h0129, 1'b0);
    step(1);
    expect_state("resume_4", 16'h0128, 1'b0);
    key(4'd5);
    expect_state("guard_key", 16'h0128, 1'b0);
    clearn = 1'b0;
    step(1);
    expect_state("guard_clr", 16'h0128, 1'b0);
    mag_on = 1'b0;
    step(1);
    clearn = 1'b1;
    expect_state("late_clr", 16'h0000, 1'b0);

    // 5: edge inputs
    load(16'h0130);
    key(4'hA);
    expect_state("bad_digit", 16'h0130, 1'b0);
    clearn = 1'b0;
    key(4'd7);
    clearn = 1'b1;
    expect_state("clr_beats_key", 16'h0000, 1'b0);
    load(16'h0130);
    mag_on = 1'b1;
    step(2);
    #2;
    rstn = 1'b0;
    #1;
    expect_state("async_rst", 16'h0000, 1'b0);
    mag_on = 1'b0;
    step(1);
    rstn = 1'b1;
    step(1);
    expect_state("post_rst", 16'h0000, 1'b0);

    // 6: beep length and cancel
    load(16'h0001);
    mag_on = 1'b1;
    step(4);
    mag_on = 1'b0;
    expect_state("beep_c0", 16'h0000, BEEP_ON);
    for (int i = 1; i < 6; i++) begin
      step(1);
      expect_state($sformatf("beep_c%0d", i), 16'h0000, BEEP_ON);
    end
    step(1);
    expect_state("beep_end", 16'h0000, 1'b0);
    load(16'h0001);
    mag_on = 1'b1;
    step(4);
    mag_on = 1'b0;
    step(1);
    expect_state("beep2_on", 16'h0000, BEEP_ON);
    key(4'd3);
    expect_state("beep_cancel", 16'h0003, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
